nco_digit_serializer: RTL

NCO_DIGIT_SERIALIZER -- requirements
Module: nco_digit_serializer

---
 rtl/nco_digit_serializer.sv | 103 ++++++++++
 1 files changed

// File: rtl/nco_digit_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : nco_digit_serializer
//  Description : Parallel-to-serial converter. A W-bit word is captured into a
//                holding buffer, moved into a shift register, and emitted
//                LSB-first as W/2 two-bit digits with valid and start-of-frame
//                flags. The buffer lets the next word arrive while the current
//                one is shifting, so consecutive words stream with no gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_digit_serializer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic         En,
    input  logic         Load,
    input  logic [W-1:0] Din,
    output logic         Rdy,
    output logic         Vld,
    output logic         Sof,
    output logic [1:0]   Dout
);

    localparam int ND = W / 2;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(ND - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          state_q;
    logic [W-1:0]    buf_q;
    logic            buf_vld_q;
    logic [W-1:0]    shift_q;
    logic [CW-1:0]   cnt_q;
    // Set on the first edge after reset release; keeps Rdy low while in reset
    // and for the rest of the cycle in which reset is released.
    logic            live_q;

    logic            accept;

    // Handshake is derived from registered state and En only, never from Load.
    assign Rdy    = En & live_q & ~buf_vld_q;
    assign accept = Load & Rdy;

    // Outputs are gated by En so a frozen block shows nothing on the bus.
    assign Vld  = En & (state_q == ST_SHIFT);
    assign Sof  = Vld & (cnt_q == '0);
    assign Dout = Vld ? shift_q[1:0] : 2'b00;

    // Buffer, shifter, digit counter and FSM; everything holds while En=0.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            live_q    <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (En) begin
                // accept implies the buffer is empty, so it never collides
                // with a transfer that clears buf_vld_q on the same edge.
                if (accept) begin
                    buf_q     <= Din;
                    buf_vld_q <= 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (buf_vld_q) begin
                            shift_q   <= buf_q;
                            buf_vld_q <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (cnt_q == LAST_DIGIT) begin
                            if (buf_vld_q) begin
                                // Reload on the last digit gives gap-free streaming.
                                shift_q   <= buf_q;
                                buf_vld_q <= 1'b0;
                                cnt_q     <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            shift_q <= {2'b00, shift_q[W-1:2]};
                            cnt_q   <= cnt_q + CW'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
